frame_response_arbiter: RTL and testbench
=========================================

Name: frame_response_arbiter

Overview:
Shares the single response frame builder between two requesters:
- Channel 0: command-response path from the AXI transaction engine. High priority.
- Channel 1: asynchronous event/notification path.

The block grants one channel at a time, muxes the granted channel's frame descriptor onto the builder inputs, issues a one-cycle build_response and tracks the frame to completion. It enforces anti-starvation for channel 1 and runs a completion watchdog. It sits between the request sources and the builder; the builder feeds the UART TX FIFO.

Parameters:
MAX_CONSEC, 4, maximum consecutive channel-0 grants while channel 1 is waiting
TIMEOUT_CYCLES, 4096, cycles allowed from issue to response_complete before timeout_err
CNT_W, 16, width of the frames_sent statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (0 = reset)
req_valid  in  2  per-channel frame request
req_status  in  2x8  per-channel status code
req_cmd  in  2x8  per-channel command echo
req_addr  in  2x32  per-channel address echo
req_is_read  in  2  per-channel read-response flag
req_data  in  2x64x8  per-channel response data bytes
req_data_count  in  2x6  per-channel data byte count
req_ack  out  2  one-cycle pulse: descriptor captured by the builder; requester may change fields or drop valid
req_done  out  2  one-cycle pulse: frame fully written to the TX FIFO
fb_status_code  out  8  to builder
fb_cmd_echo  out  8  to builder
fb_addr_echo  out  32  to builder
fb_response_data  out  64x8  to builder
fb_response_data_count  out  6  to builder
fb_is_read_response  out  1  to builder
fb_build_response  out  1  to builder
fb_builder_busy  in  1  from builder
fb_response_complete  in  1  from builder
err_clr  in  1  clears timeout_err
timeout_err  out  1  sticky watchdog flag
grant_id  out  1  channel currently or last granted
frames_sent  out  CNT_W  completed-frame count, wraps

Behaviour:
- Reset (rst==0 at a clk edge) sets:
  - state=IDLE; grant_reg=0; consec_cnt=0; wdog=0; frames_sent=0; timeout_err=0.
  - req_ack, req_done and fb_build_response are 0.
- Builder outputs are a combinational mux of channel grant_reg. grant_id = grant_reg.
- States:
  - IDLE:
    - Arbitrates only when fb_builder_busy==0 and at least one req_valid bit is set.
    - Winner is channel 1 if req_valid[1] && (!req_valid[0] || consec_cnt>=MAX_CONSEC); otherwise channel 0.
    - Latches grant_reg, then goes to ISSUE.
  - ISSUE:
    - fb_build_response = !fb_builder_busy. In the same cycle req_ack[grant_reg]=1 and wdog is cleared; then goes to WAIT_DONE.
    - If fb_builder_busy==1, stays in ISSUE with no ack.
  - WAIT_DONE:
    - wdog increments each cycle.
    - On fb_response_complete: req_done[grant_reg]=1, frames_sent+1 (wraps at 2^CNT_W), then goes to IDLE.
    - When wdog reaches TIMEOUT_CYCLES-1 without completion: timeout_err<=1 and the block keeps waiting (the builder cannot be aborted). wdog saturates.
- Anti-starvation counter, updated in IDLE at grant:
  - Channel 0 granted with req_valid[1]=1: consec_cnt+1, saturating at MAX_CONSEC.
  - Channel 1 granted, or req_valid[1]=0: consec_cnt=0.
- Latency and throughput:
  - Request to fb_build_response: 2 cycles (IDLE, then ISSUE).
  - Minimum gap between frames: 1 IDLE cycle after response_complete.
- Requesters must hold their descriptor and req_valid stable until req_ack. Dropping valid before ack is illegal; it is flagged by an assertion, not handled.
- err_clr takes priority over a same-cycle timeout set. timeout_err returns to 0 only on err_clr or reset.
- Reset mid-frame:
  - The arbiter returns to IDLE; this reset does not reset the builder.
  - After reset the arbiter issues nothing until fb_builder_busy==0, so an orphaned frame is allowed to finish. No req_done is generated for it.
- req_ack and req_done are never asserted for both channels in the same cycle.

Decomposition:
- Shared package uart_axi_pkg holds:
  - arb_state_t enum: IDLE, ISSUE, WAIT_DONE.
  - NUM_CH=2 and the CH_CMD and CH_EVT channel index constants.
  - The frame_desc_t struct: status, cmd, addr, is_read, data[64], count.
  - The status code constants.
- One natural sub-module: frame_desc_mux, a parameterised descriptor selector with no state. The arbiter FSM, counters and watchdog stay in the top module.

Test Plan:
- Channel 0 only: status=0x00, cmd=0xA0, addr=0x1000_0004, is_read=1, count=4 -> fb_build_response 2 cycles after valid; req_ack[0] in the same cycle; req_done[0] on response_complete; frames_sent=1.
- Both channels valid continuously, MAX_CONSEC=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; consec_cnt resets after each channel-1 grant.
- Channel 1 alone with count=0 and is_read=0 -> channel 1 granted immediately; grant_id=1; the other channel's ack/done stay 0.
- Builder model never asserts complete, TIMEOUT_CYCLES=16 -> timeout_err rises at cycle 15 after issue. Raising err_clr on that same cycle keeps it 0. A later complete still produces req_done.
- Reset asserted while fb_builder_busy=1 and channel 0 is valid -> no fb_build_response until busy falls; then the frame is issued normally; no req_done for the aborted grant.
- frames_sent at 0xFFFF plus one completed frame -> 0x0000.

Source files
------------

// File: rtl/uart_axi_pkg.sv
// Shared types and constants for the UART/AXI response path.
// Holds the arbiter state encoding, channel indices and the response frame descriptor.
package uart_axi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } arb_state_t;

  localparam int NUM_CH   = 2;
  localparam int CH_CMD   = 0;
  localparam int CH_EVT   = 1;
  localparam int MAX_DATA = 64;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_SLVERR  = 8'h02;
  localparam logic [7:0] ST_DECERR  = 8'h03;
  localparam logic [7:0] ST_TIMEOUT = 8'h04;
  localparam logic [7:0] ST_EVENT   = 8'h80;

  typedef struct packed {
    logic [7:0]                status;
    logic [7:0]                cmd;
    logic [31:0]               addr;
    logic                      is_read;
    logic [MAX_DATA-1:0][7:0]  data;
    logic [5:0]                count;
  } frame_desc_t;

endpackage

// File: rtl/frame_response_arbiter_mux.sv
// Purpose: selects one frame descriptor out of N by index.
// Latency: combinational, no state.
// Backpressure: none; the caller owns all flow control.
module frame_desc_mux
  import uart_axi_pkg::*;
#(
  parameter int N     = NUM_CH,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  frame_desc_t             desc [N],
  input  logic [SEL_W-1:0]        sel,
  output frame_desc_t             desc_out
);

  assign desc_out = desc[sel];

endmodule

// File: rtl/frame_response_arbiter.sv
// Purpose: shares the response frame builder between the command path (ch0) and the event path (ch1).
// Latency: request to fb_build_response 2 cycles; 1 idle cycle between frames.
// Backpressure: holds in IDLE/ISSUE while fb_builder_busy; requesters hold valid until req_ack.
module frame_response_arbiter
  import uart_axi_pkg::*;
#(
  parameter int MAX_CONSEC     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH-1:0][7:0]       req_status,
  input  logic [NUM_CH-1:0][7:0]       req_cmd,
  input  logic [NUM_CH-1:0][31:0]      req_addr,
  input  logic [NUM_CH-1:0]            req_is_read,
  input  logic [NUM_CH-1:0][63:0][7:0] req_data,
  input  logic [NUM_CH-1:0][5:0]       req_data_count,
  output logic [NUM_CH-1:0]            req_ack,
  output logic [NUM_CH-1:0]            req_done,
  output logic [7:0]                   fb_status_code,
  output logic [7:0]                   fb_cmd_echo,
  output logic [31:0]                  fb_addr_echo,
  output logic [63:0][7:0]             fb_response_data,
  output logic [5:0]                   fb_response_data_count,
  output logic                         fb_is_read_response,
  output logic                         fb_build_response,
  input  logic                         fb_builder_busy,
  input  logic                         fb_response_complete,
  input  logic                         err_clr,
  output logic                         timeout_err,
  output logic                         grant_id,
  output logic [CNT_W-1:0]             frames_sent
);

  localparam int CONS_W = $clog2(MAX_CONSEC + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(MAX_CONSEC);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t          state;
  logic                grant_reg;
  logic [CONS_W-1:0]   consec_cnt;
  logic [WD_W-1:0]     wdog;

  frame_desc_t desc [NUM_CH];
  frame_desc_t sel_desc;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_desc
    assign desc[i] = '{status:  req_status[i],
                       cmd:     req_cmd[i],
                       addr:    req_addr[i],
                       is_read: req_is_read[i],
                       data:    req_data[i],
                       count:   req_data_count[i]};
  end

  frame_desc_mux #(.N(NUM_CH)) u_mux (
    .desc     (desc),
    .sel      (grant_reg),
    .desc_out (sel_desc)
  );

  assign fb_status_code         = sel_desc.status;
  assign fb_cmd_echo            = sel_desc.cmd;
  assign fb_addr_echo           = sel_desc.addr;
  assign fb_is_read_response    = sel_desc.is_read;
  assign fb_response_data       = sel_desc.data;
  assign fb_response_data_count = sel_desc.count;
  assign grant_id               = grant_reg;

  // Event channel wins when it is alone or has been passed over MAX_CONSEC times.
  logic ch1_wins;
  logic issue_fire;
  logic done_fire;
  logic wd_hit;

  assign ch1_wins   = req_valid[CH_EVT] && (!req_valid[CH_CMD] || consec_cnt >= CONS_MAX);
  assign issue_fire = (state == ISSUE) && !fb_builder_busy;
  assign done_fire  = (state == WAIT_DONE) && fb_response_complete;
  assign wd_hit     = (state == WAIT_DONE) && !fb_response_complete && (wdog == WD_LAST - 1'b1);

  assign fb_build_response = issue_fire;

  always_comb begin
    req_ack             = '0;
    req_done            = '0;
    req_ack[grant_reg]  = issue_fire;
    req_done[grant_reg] = done_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      grant_reg   <= 1'b0;
      consec_cnt  <= '0;
      wdog        <= '0;
      frames_sent <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Waiting for busy to drop also lets a frame orphaned by reset drain.
          if (!fb_builder_busy && |req_valid) begin
            grant_reg <= ch1_wins;
            if (!ch1_wins && req_valid[CH_EVT])
              consec_cnt <= (consec_cnt >= CONS_MAX) ? CONS_MAX : consec_cnt + 1'b1;
            else
              consec_cnt <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!fb_builder_busy) begin
            wdog  <= '0;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (fb_response_complete) begin
            frames_sent <= frames_sent + 1'b1;
            state       <= IDLE;
          end else if (wdog != WD_LAST) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (err_clr)
        timeout_err <= 1'b0;
      else if (wd_hit)
        timeout_err <= 1'b1;
    end
  end

  a_valid_held: assert property (@(posedge clk) disable iff (!rst)
    (state == ISSUE) |-> req_valid[grant_reg]);

endmodule

// File: tb/tb_frame_response_arbiter.sv
// Directed bench for frame_response_arbiter: cycle table plus fairness, watchdog, reset and wrap sequences.
module tb_frame_response_arbiter;
  import uart_axi_pkg::*;

  localparam int MAXC = 4;
  localparam int TMO  = 16;
  localparam int CW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [1:0]             req_valid;
  logic [1:0][7:0]        req_status;
  logic [1:0][7:0]        req_cmd;
  logic [1:0][31:0]       req_addr;
  logic [1:0]             req_is_read;
  logic [1:0][63:0][7:0]  req_data;
  logic [1:0][5:0]        req_data_count;
  logic [1:0]             req_ack;
  logic [1:0]             req_done;
  logic [7:0]             fb_status_code;
  logic [7:0]             fb_cmd_echo;
  logic [31:0]            fb_addr_echo;
  logic [63:0][7:0]       fb_response_data;
  logic [5:0]             fb_response_data_count;
  logic                   fb_is_read_response;
  logic                   fb_build_response;
  logic                   fb_builder_busy;
  logic                   fb_response_complete;
  logic                   err_clr;
  logic                   timeout_err;
  logic                   grant_id;
  logic [CW-1:0]          frames_sent;

  frame_desc_t d [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_status[i]     = d[i].status;
      req_cmd[i]        = d[i].cmd;
      req_addr[i]       = d[i].addr;
      req_is_read[i]    = d[i].is_read;
      req_data[i]       = d[i].data;
      req_data_count[i] = d[i].count;
    end
  end

  frame_response_arbiter #(
    .MAX_CONSEC     (MAXC),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_valid              (req_valid),
    .req_status             (req_status),
    .req_cmd                (req_cmd),
    .req_addr               (req_addr),
    .req_is_read            (req_is_read),
    .req_data               (req_data),
    .req_data_count         (req_data_count),
    .req_ack                (req_ack),
    .req_done               (req_done),
    .fb_status_code         (fb_status_code),
    .fb_cmd_echo            (fb_cmd_echo),
    .fb_addr_echo           (fb_addr_echo),
    .fb_response_data       (fb_response_data),
    .fb_response_data_count (fb_response_data_count),
    .fb_is_read_response    (fb_is_read_response),
    .fb_build_response      (fb_build_response),
    .fb_builder_busy        (fb_builder_busy),
    .fb_response_complete   (fb_response_complete),
    .err_clr                (err_clr),
    .timeout_err            (timeout_err),
    .grant_id               (grant_id),
    .frames_sent            (frames_sent)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] vld;
    logic       busy;
    logic       cmpl;
    logic [1:0] ack;
    logic [1:0] done;
    logic       build;
    logic       gid;
    logic       mux;
    logic [7:0] frames;
  } vec_t;

  vec_t tbl [22];

  // Called just after a posedge with the arbiter idle; returns just after the completing posedge.
  task automatic do_frame(input logic [1:0] vld);
    int n;
    req_valid = vld;
    n = 0;
    @(negedge clk);
    while (!fb_build_response && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("frame_issue_bound", 64'(n < 8), 64'd1);
    @(posedge clk); #1;
    req_valid            = 2'b00;
    fb_response_complete = 1'b1;
    @(posedge clk); #1;
    fb_response_complete = 1'b0;
  endtask

  task automatic timeout_frame(input bit clr_mode);
    int n;
    req_valid = 2'b01;
    n = 0;
    @(negedge clk);
    while (!fb_build_response && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_issue_bound", 64'(n < 8), 64'd1);
    // j counts posedges from the issue edge; the flag must rise at the 15th.
    for (int j = 0; j <= 17; j++) begin
      @(posedge clk); #1;
      req_valid       = 2'b00;
      fb_builder_busy = 1'b1;
      err_clr         = (clr_mode && j == 14);
      @(negedge clk);
      if (j >= 13)
        chk($sformatf("tmo_err_c%0d_j%0d", clr_mode, j), 64'(timeout_err),
            64'(!clr_mode && j >= 15));
    end
    if (!clr_mode) begin
      @(posedge clk); #1; err_clr = 1'b1;
      @(posedge clk); #1; err_clr = 1'b0;
      @(negedge clk);
      chk("tmo_err_cleared", 64'(timeout_err), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tmo_err_stays_clear", 64'(timeout_err), 64'd0);
    end
    @(posedge clk); #1;
    fb_builder_busy      = 1'b0;
    fb_response_complete = 1'b1;
    @(negedge clk);
    chk($sformatf("tmo_late_done_c%0d", clr_mode), 64'(req_done), 64'b01);
    @(posedge clk); #1;
    fb_response_complete = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected end before 100000");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   n;
    int   exp_seq [10];
    logic g;

    d[0]         = '0;
    d[0].status  = ST_OK;
    d[0].cmd     = 8'hA0;
    d[0].addr    = 32'h1000_0004;
    d[0].is_read = 1'b1;
    d[0].count   = 6'd4;
    for (int i = 0; i < 4; i++) d[0].data[i] = 8'(8'h11 * (i + 1));
    d[1]         = '0;
    d[1].status  = ST_EVENT;
    d[1].cmd     = 8'h5E;
    d[1].addr    = 32'h2000_0010;
    d[1].is_read = 1'b0;
    d[1].count   = 6'd0;
    for (int i = 0; i < 64; i++) d[1].data[i] = 8'(8'h80 + i);

    rst                  = 1'b0;
    req_valid            = 2'b00;
    fb_builder_busy      = 1'b0;
    fb_response_complete = 1'b0;
    err_clr              = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_frames", 64'(frames_sent), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_ack", 64'(req_ack), 64'd0);
    chk("rst_done", 64'(req_done), 64'd0);
    chk("rst_build", 64'(fb_build_response), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    //          vld   busy  cmpl  ack    done   bld   gid   mux   frames
    tbl[0]  = '{2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[2]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[6]  = '{2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[8]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[9]  = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[10] = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 8'd2};
    tbl[11] = '{2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 8'd2};
    tbl[12] = '{2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[13] = '{2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 8'd2};
    tbl[14] = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[15] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[16] = '{2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[17] = '{2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[18] = '{2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[19] = '{2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 8'd3};
    tbl[20] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[21] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd4};

    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      req_valid            = tbl[i].vld;
      fb_builder_busy      = tbl[i].busy;
      fb_response_complete = tbl[i].cmpl;
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), 64'(req_ack), 64'(tbl[i].ack));
      chk($sformatf("v%0d_done", i), 64'(req_done), 64'(tbl[i].done));
      chk($sformatf("v%0d_build", i), 64'(fb_build_response), 64'(tbl[i].build));
      chk($sformatf("v%0d_gid", i), 64'(grant_id), 64'(tbl[i].gid));
      chk($sformatf("v%0d_frames", i), 64'(frames_sent), 64'(tbl[i].frames));
      if (tbl[i].mux) begin
        g = tbl[i].gid;
        chk($sformatf("v%0d_status", i), 64'(fb_status_code), 64'(d[g].status));
        chk($sformatf("v%0d_cmd", i), 64'(fb_cmd_echo), 64'(d[g].cmd));
        chk($sformatf("v%0d_addr", i), 64'(fb_addr_echo), 64'(d[g].addr));
        chk($sformatf("v%0d_is_read", i), 64'(fb_is_read_response), 64'(d[g].is_read));
        chk($sformatf("v%0d_count", i), 64'(fb_response_data_count), 64'(d[g].count));
        chk($sformatf("v%0d_data", i), 64'(fb_response_data == d[g].data), 64'd1);
      end
    end

    // Both channels requesting back to back.
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int f = 0; f < 10; f++) begin
      @(posedge clk); #1;
      req_valid            = 2'b11;
      fb_response_complete = 1'b0;
      n = 0;
      @(negedge clk);
      while (!fb_build_response && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("fair%0d_issue_bound", f), 64'(n < 8), 64'd1);
      chk($sformatf("fair%0d_grant", f), 64'(grant_id), 64'(exp_seq[f]));
      g = grant_id;
      @(posedge clk); #1;
      fb_response_complete = 1'b1;
      @(negedge clk);
      chk($sformatf("fair%0d_done", f), 64'(req_done), 64'(2'b01 << exp_seq[f]));
    end
    @(posedge clk); #1;
    req_valid            = 2'b00;
    fb_response_complete = 1'b0;
    @(negedge clk);
    chk("fair_frames", 64'(frames_sent), 64'd14);
    @(posedge clk); #1;

    timeout_frame(1'b0);
    timeout_frame(1'b1);
    @(negedge clk);
    chk("tmo_frames", 64'(frames_sent), 64'd16);
    chk("tmo_err_after", 64'(timeout_err), 64'd0);
    @(posedge clk); #1;

    // Reset while a frame is in flight and a new request is pending.
    req_valid = 2'b01;
    n = 0;
    @(negedge clk);
    while (!fb_build_response && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("mrst_issue_bound", 64'(n < 8), 64'd1);
    @(posedge clk); #1;
    req_valid       = 2'b00;
    fb_builder_busy = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b01;
    rst       = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_frames", 64'(frames_sent), 64'd0);
    chk("mrst_build0", 64'(fb_build_response), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("mrst_hold%0d_build", k), 64'(fb_build_response), 64'd0);
      chk($sformatf("mrst_hold%0d_ack", k), 64'(req_ack), 64'd0);
    end
    @(posedge clk); #1;
    fb_builder_busy      = 1'b0;
    fb_response_complete = 1'b1;
    @(negedge clk);
    chk("mrst_orphan_no_done", 64'(req_done), 64'd0);
    @(posedge clk); #1;
    fb_response_complete = 1'b0;
    @(negedge clk);
    chk("mrst_reissue_build", 64'(fb_build_response), 64'd1);
    chk("mrst_reissue_ack", 64'(req_ack), 64'b01);
    @(posedge clk); #1;
    req_valid       = 2'b00;
    fb_builder_busy = 1'b1;
    @(posedge clk); #1;
    fb_builder_busy      = 1'b0;
    fb_response_complete = 1'b1;
    @(negedge clk);
    chk("mrst_done", 64'(req_done), 64'b01);
    @(posedge clk); #1;
    fb_response_complete = 1'b0;
    @(negedge clk);
    chk("mrst_frames_after", 64'(frames_sent), 64'd1);
    @(posedge clk); #1;

    // Counter wrap at the configured width.
    for (int k = 0; k < 254; k++) do_frame(2'b01);
    @(negedge clk);
    chk("wrap_at_max", 64'(frames_sent), 64'hFF);
    @(posedge clk); #1;
    do_frame(2'b01);
    @(negedge clk);
    chk("wrap_to_zero", 64'(frames_sent), 64'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
